// File: rtl/col_t2b_pkg.sv
// Shared types and encode helpers for the column thermometer-to-binary encoder.
package col_t2b_pkg;

    localparam int unsigned N = 16;
    localparam int unsigned W = 4;

    typedef logic [N-1:0] therm_t;
    typedef logic [W-1:0] bin_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Majority vote over each bit and its neighbours; bit 0 is forced high and bit N reads as 0.
    function automatic therm_t bubble_fix(input therm_t r);
        logic [N:0] re;
        therm_t     c;
        re   = {1'b0, r};
        c    = '0;
        c[0] = 1'b1;
        for (int unsigned k = 1; k < N; k++) begin
            c[k] = maj3(re[k-1], re[k], re[k+1]);
        end
        return c;
    endfunction

    // Counts bits 1..N-1 only, so the result fits in W bits.
    function automatic bin_t therm_popcount(input therm_t c);
        bin_t cnt;
        cnt = '0;
        for (int unsigned k = 1; k < N; k++) begin
            cnt = cnt + bin_t'(c[k]);
        end
        return cnt;
    endfunction

    function automatic therm_t fall_expected(input therm_t r);
        return {1'b1, ~r[N-1:1]};
    endfunction

endpackage

// File: rtl/col_t2b_enc_sync.sv
// Free-running flop chain with asynchronous clear, used once per synchronised bus.
module col_t2b_enc_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[STAGES-1];

endmodule

// File: rtl/col_t2b_enc.sv
// Column thermometer-to-binary encoder: sync, bubble-fix/encode, one-entry valid/ready output.
// Optional saturating error counter enabled by defining COL_T2B_ERRCNT_EN.
module col_t2b_enc
    import col_t2b_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sample_i,
    input  logic [N-1:0] rise_i,
    input  logic [N-1:0] fall_i,
    input  logic         ready_i,
    output logic [W-1:0] bin_o,
    output logic         valid_o,
    output logic         err_o,
    output logic         drop_o,
    output logic [7:0]   err_cnt_o
);

    therm_t rise_s;
    therm_t fall_s;
    logic   sample_s;

    col_t2b_enc_sync #(.WIDTH(N), .STAGES(SYNC_STAGES)) u_sync_rise (
        .clk (clk),
        .rst (rst),
        .d   (rise_i),
        .q   (rise_s)
    );

    col_t2b_enc_sync #(.WIDTH(N), .STAGES(SYNC_STAGES)) u_sync_fall (
        .clk (clk),
        .rst (rst),
        .d   (fall_i),
        .q   (fall_s)
    );

    col_t2b_enc_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sync_sample (
        .clk (clk),
        .rst (rst),
        .d   (sample_i),
        .q   (sample_s)
    );

    therm_t fixed;
    logic   enc_err;

    assign fixed   = bubble_fix(rise_s);
    assign enc_err = (rise_s != fixed) | ~rise_s[0] | (fall_s != fall_expected(rise_s));

    logic s1_valid;
    bin_t s1_bin;
    logic s1_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_bin   <= '0;
            s1_err   <= 1'b0;
        end else begin
            s1_valid <= sample_s;
            if (sample_s) begin
                s1_bin <= therm_popcount(fixed);
                s1_err <= enc_err;
            end
        end
    end

    logic out_valid;
    bin_t out_bin;
    logic out_err;
    logic load;

    // Loading while the held entry is accepted keeps full throughput.
    assign load = s1_valid & (~out_valid | ready_i);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
        end else begin
            out_valid <= load | (out_valid & ~ready_i);
            if (load) begin
                out_bin <= s1_bin;
                out_err <= s1_err;
            end
        end
    end

    assign valid_o = out_valid;
    assign bin_o   = out_bin;
    assign err_o   = out_err;
    assign drop_o  = s1_valid & out_valid & ~ready_i;

`ifdef COL_T2B_ERRCNT_EN
    logic [7:0] err_cnt;

    // Counts every erroneous S1 result, including ones dropped at the output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt <= 8'd0;
        end else if (s1_valid && s1_err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt;
`else
    assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_col_t2b_enc.sv
// Directed self-checking bench for col_t2b_enc with SYNC_STAGES=2.
module tb_col_t2b_enc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sample_i;
    logic [15:0] rise_i;
    logic [15:0] fall_i;
    logic        ready_i;
    logic [3:0]  bin_o;
    logic        valid_o;
    logic        err_o;
    logic        drop_o;
    logic [7:0]  err_cnt_o;

    int checks = 0;
    int passes = 0;

`ifdef COL_T2B_ERRCNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    always #5 clk = ~clk;

    col_t2b_enc #(.SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .sample_i  (sample_i),
        .rise_i    (rise_i),
        .fall_i    (fall_i),
        .ready_i   (ready_i),
        .bin_o     (bin_o),
        .valid_o   (valid_o),
        .err_o     (err_o),
        .drop_o    (drop_o),
        .err_cnt_o (err_cnt_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic s, input logic [15:0] r, input logic [15:0] f);
        sample_i = s;
        rise_i   = r;
        fall_i   = f;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0001, 16'hFFFF);
    endtask

    initial begin
        rst     = 1'b1;
        ready_i = 1'b1;
        idle();
        tick();
        tick();
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_bin", 32'(bin_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_drop", 32'(drop_o), 32'd0);
        check("rst_cnt", 32'(err_cnt_o), 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();

        // Single legal sample, bin 0, four-cycle latency
        drive(1'b1, 16'h0001, 16'hFFFF);
        tick();
        idle();
        tick();
        tick();
        check("t1_early_valid", 32'(valid_o), 32'd0);
        tick();
        check("t1_valid", 32'(valid_o), 32'd1);
        check("t1_bin", 32'(bin_o), 32'd0);
        check("t1_err", 32'(err_o), 32'd0);
        tick();
        check("t1_valid_fall", 32'(valid_o), 32'd0);

        // Back-to-back legal samples: full scale then bin 2
        drive(1'b1, 16'hFFFF, 16'h8000);
        tick();
        drive(1'b1, 16'h0007, 16'hFFFC);
        tick();
        idle();
        tick();
        tick();
        check("t2a_valid", 32'(valid_o), 32'd1);
        check("t2a_bin", 32'(bin_o), 32'd15);
        check("t2a_err", 32'(err_o), 32'd0);
        tick();
        check("t2b_valid", 32'(valid_o), 32'd1);
        check("t2b_bin", 32'(bin_o), 32'd2);
        check("t2b_err", 32'(err_o), 32'd0);
        tick();
        check("t2_valid_fall", 32'(valid_o), 32'd0);

        // Bubble then rise/fall mismatch
        drive(1'b1, 16'h00DF, 16'hFF80);
        tick();
        drive(1'b1, 16'h000F, 16'hFFFF);
        tick();
        idle();
        tick();
        tick();
        check("t3_bubble_bin", 32'(bin_o), 32'd7);
        check("t3_bubble_err", 32'(err_o), 32'd1);
        tick();
        check("t3_mism_bin", 32'(bin_o), 32'd3);
        check("t3_mism_err", 32'(err_o), 32'd1);
        tick();
        check("t3_valid_fall", 32'(valid_o), 32'd0);

        // Backpressure: second result dropped, first held
        ready_i = 1'b0;
        drive(1'b1, 16'h0003, 16'hFFFE);
        tick();
        drive(1'b1, 16'h0007, 16'hFFFC);
        tick();
        idle();
        tick();
        check("t4_drop_early", 32'(drop_o), 32'd0);
        tick();
        check("t4_valid", 32'(valid_o), 32'd1);
        check("t4_bin", 32'(bin_o), 32'd1);
        check("t4_drop", 32'(drop_o), 32'd1);
        tick();
        check("t4_hold_valid", 32'(valid_o), 32'd1);
        check("t4_hold_bin", 32'(bin_o), 32'd1);
        check("t4_drop_once", 32'(drop_o), 32'd0);
        ready_i = 1'b1;
        tick();
        check("t4_valid_fall", 32'(valid_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_no_bin2", 32'(valid_o), 32'd0);
        end

        // Reset with a held result and a sample in flight
        ready_i = 1'b0;
        drive(1'b1, 16'h00DF, 16'hFF80);
        tick();
        idle();
        tick();
        tick();
        tick();
        check("t5_held_valid", 32'(valid_o), 32'd1);
        check("t5_held_bin", 32'(bin_o), 32'd7);
        drive(1'b1, 16'h0007, 16'hFFFC);
        tick();
        idle();
        tick();
        rst = 1'b1;
        #1;
        check("t5_rst_valid", 32'(valid_o), 32'd0);
        check("t5_rst_bin", 32'(bin_o), 32'd0);
        check("t5_rst_err", 32'(err_o), 32'd0);
        check("t5_rst_drop", 32'(drop_o), 32'd0);
        check("t5_rst_cnt", 32'(err_cnt_o), 32'd0);
        tick();
        rst     = 1'b0;
        ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("t5_no_valid", 32'(valid_o), 32'd0);
        end

        // Error counter: three bubbles, then saturation
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h00DF, 16'hFF80);
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("t6_cnt3", 32'(err_cnt_o), CntEn ? 32'd3 : 32'd0);
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'h00DF, 16'hFF80);
            tick();
        end
        idle();
        for (int i = 0; i < 5; i++) tick();
        check("t6_cnt_sat", 32'(err_cnt_o), CntEn ? 32'd255 : 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
